// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the instruction fetch buffer
package rv_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/rv_sync_fifo.sv
// rtl/rv_sync_fifo.sv - synchronous FIFO with flush and occupancy count, no bypass
module rv_sync_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Pointers wrap naturally because DEPTH is a power of two; flush wins over push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= push_data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_i) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/rv_fetch_buffer.sv
// rtl/rv_fetch_buffer.sv - fetch PC, ICCM read issue and instruction FIFO; RV_FETCH_BYPASS_EN adds empty-FIFO forwarding
module rv_fetch_buffer
    import rv_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      fetch_pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic [31:0]      redirect_aligned;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             resp_ok;
    logic             fifo_valid;
    logic             fifo_pop;
    logic             push;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    // Credit counts the read in flight but not a same-cycle pop, keeping ready off the enable path.
    assign occupancy        = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue            = rst_ni && !redirect_i && (occupancy < (CNT_W + 1)'(DEPTH));
    assign mem_en_o         = issue;
    assign mem_addr_o       = fetch_pc[ADDR_W+1:2];
    assign redirect_aligned = redirect_pc_i & ~32'h0000_0003;
    assign resp_ok          = inflight && !redirect_i;
    assign fifo_valid       = (count != '0);
    assign fifo_pop         = fifo_valid && instr_ready_i;
    assign push_entry       = '{pc: inflight_pc, instr: mem_rdata_i};

`ifdef RV_FETCH_BYPASS_EN
    logic bypass;
    assign bypass        = !fifo_valid && resp_ok;
    assign instr_valid_o = fifo_valid || bypass;
    assign instr_o       = bypass ? mem_rdata_i : head.instr;
    assign pc_o          = bypass ? inflight_pc : head.pc;
    assign push          = resp_ok && !(bypass && instr_ready_i);
`else
    assign instr_valid_o = fifo_valid;
    assign instr_o       = head.instr;
    assign pc_o          = head.pc;
    assign push          = resp_ok;
`endif

    // Fetch PC and in-flight tracking; a redirect squashes the outstanding read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_aligned;
            inflight <= 1'b0;
        end else if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'(INSTR_BYTES);
        end else begin
            inflight <= 1'b0;
        end
    end

    rv_sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .count_o     (count)
    );

endmodule

// File: tb/tb_rv_fetch_buffer.sv
// tb/tb_rv_fetch_buffer.sv - self-checking bench for rv_fetch_buffer against a sequential-PC stream model
module tb_rv_fetch_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
`ifdef RV_FETCH_BYPASS_EN
    localparam int LAT_RST = 1;
    localparam int LAT_RDR = 2;
`else
    localparam int LAT_RST = 2;
    localparam int LAT_RDR = 3;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              mem_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_rdata_i = '0;
    logic              instr_valid_o;
    logic              instr_ready_i = 1'b0;
    logic [31:0]       instr_o;
    logic [31:0]       pc_o;
    logic              redirect_i = 1'b0;
    logic [31:0]       redirect_pc_i = '0;

    logic [31:0] iccm [256];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          issues = 0;
    logic        hs;
    logic [31:0] hpc;
    logic [31:0] hins;
    int          hcyc;

    rv_fetch_buffer #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .mem_en_o      (mem_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk_i = ~clk_i;

    // ICCM: one-cycle read latency
    always @(posedge clk_i) begin
        if (mem_en_o) mem_rdata_i <= iccm[mem_addr_o];
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [31:0] p;
        p = pc;
        return iccm[p[9:2]];
    endfunction

    // One cycle: observe handshake before the edge, advance to next negedge.
    task automatic tick();
        #1;
        hs   = instr_valid_o && instr_ready_i;
        hpc  = pc_o;
        hins = instr_o;
        hcyc = cyc;
        if (mem_en_o) issues++;
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic do_reset(input logic rdy);
        rst_ni        = 1'b0;
        redirect_i    = 1'b0;
        instr_ready_i = rdy;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        cyc    = 0;
        issues = 0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        n_total++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid_o); else n_pass++;
        n_total++; if (mem_en_o !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en_o); else n_pass++;
        n_total++; if (instr_o !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr_o); else n_pass++;
        n_total++; if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h want 0", pc_o); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1; cyc = 0;
        #1;
        n_total++; if (mem_en_o !== 1'b1) $display("FAIL reset_first_issue: got %b want 1", mem_en_o); else n_pass++;
        n_total++; if (mem_addr_o !== 8'h00) $display("FAIL reset_first_addr: got %h want 00", mem_addr_o); else n_pass++;
        @(negedge clk_i);
    endtask

    task automatic test_startup_stream();
        int k;
        do_reset(1'b1);
        k = 0;
        repeat (8) begin
            tick();
            if (hs && k < 4) begin
                n_total++; if (hpc !== 32'(4 * k)) $display("FAIL start_pc%0d: got %h want %h", k, hpc, 4 * k); else n_pass++;
                n_total++; if (hins !== iccm[k]) $display("FAIL start_instr%0d: got %h want %h", k, hins, iccm[k]); else n_pass++;
                n_total++; if (hcyc != LAT_RST + k) $display("FAIL start_cycle%0d: got %0d want %0d", k, hcyc, LAT_RST + k); else n_pass++;
            end
            if (hs) k++;
        end
        n_total++; if (k < 4) $display("FAIL start_count: got %0d want >=4", k); else n_pass++;
    endtask

    task automatic test_stall();
        int k;
        do_reset(1'b0);
        repeat (10) tick();
        n_total++; if (issues != DEPTH) $display("FAIL stall_issues: got %0d want %0d", issues, DEPTH); else n_pass++;
        #1;
        n_total++; if (mem_en_o !== 1'b0) $display("FAIL stall_mem_en: got %b want 0", mem_en_o); else n_pass++;
        instr_ready_i = 1'b1;
        k = 0;
        repeat (12) begin
            tick();
            if (hs && k < 6) begin
                n_total++; if (hpc !== 32'(4 * k)) $display("FAIL drain_pc%0d: got %h want %h", k, hpc, 4 * k); else n_pass++;
                n_total++; if (hins !== iccm[k]) $display("FAIL drain_instr%0d: got %h want %h", k, hins, iccm[k]); else n_pass++;
            end
            if (hs) k++;
        end
        n_total++; if (k < 6) $display("FAIL drain_count: got %0d want >=6", k); else n_pass++;
    endtask

    task automatic test_redirect_flush();
        int k, n;
        logic [31:0] e;
        do_reset(1'b0);
        repeat (4) tick();
        #1;
        n_total++; if (instr_valid_o !== 1'b1) $display("FAIL flush_pre_valid: got %b want 1", instr_valid_o); else n_pass++;
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040;
        n = cyc;
        tick();
        redirect_i = 1'b0; instr_ready_i = 1'b1;
        #1;
        n_total++; if (mem_en_o !== 1'b1) $display("FAIL flush_issue: got %b want 1", mem_en_o); else n_pass++;
        n_total++; if (mem_addr_o !== 8'h10) $display("FAIL flush_addr: got %h want 10", mem_addr_o); else n_pass++;
        k = 0;
        repeat (8) begin
            tick();
            if (hs && k < 3) begin
                e = 32'h40 + 32'(4 * k);
                n_total++; if (hpc !== e) $display("FAIL flush_pc%0d: got %h want %h", k, hpc, e); else n_pass++;
                n_total++; if (hins !== word_at(e)) $display("FAIL flush_instr%0d: got %h want %h", k, hins, word_at(e)); else n_pass++;
                if (k == 0) begin
                    n_total++; if (hcyc != n + LAT_RDR) $display("FAIL flush_latency: got %0d want %0d", hcyc, n + LAT_RDR); else n_pass++;
                end
            end
            if (hs) k++;
        end
        n_total++; if (k < 3) $display("FAIL flush_count: got %0d want >=3", k); else n_pass++;
    endtask

    task automatic test_redirect_unaligned();
        int k;
        logic [31:0] e;
        do_reset(1'b1);
        repeat (5) tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0023;
        tick();
        redirect_i = 1'b0;
        k = 0;
        repeat (6) begin
            tick();
            if (hs && k == 0) begin
                n_total++; if (hpc !== 32'h20) $display("FAIL unal_pc: got %h want 00000020", hpc); else n_pass++;
                n_total++; if (hins !== iccm[8]) $display("FAIL unal_instr: got %h want %h", hins, iccm[8]); else n_pass++;
            end
            if (hs) k++;
        end
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        redirect_i = 1'b0;
        k = 0;
        repeat (8) begin
            tick();
            if (hs && k < 3) begin
                e = 32'hFFFF_FFFC + 32'(4 * k);
                n_total++; if (hpc !== e) $display("FAIL wrap_pc%0d: got %h want %h", k, hpc, e); else n_pass++;
                n_total++; if (hins !== word_at(e)) $display("FAIL wrap_instr%0d: got %h want %h", k, hins, word_at(e)); else n_pass++;
            end
            if (hs) k++;
        end
        n_total++; if (k < 3) $display("FAIL wrap_count: got %0d want >=3", k); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int k, bad;
        do_reset(1'b1);
        repeat (4) tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        tick();
        n_total++; if (hs !== 1'b1) $display("FAIL b2b_handshake: got %b want 1", hs); else n_pass++;
        redirect_pc_i = 32'h0000_0080;
        tick();
        redirect_i = 1'b0;
        k = 0; bad = 0;
        repeat (8) begin
            tick();
            if (hs && hpc == 32'h200) bad++;
            if (hs && k == 0) begin
                n_total++; if (hpc !== 32'h80) $display("FAIL b2b_first_pc: got %h want 00000080", hpc); else n_pass++;
                n_total++; if (hins !== iccm[32]) $display("FAIL b2b_first_instr: got %h want %h", hins, iccm[32]); else n_pass++;
            end
            if (hs) k++;
        end
        n_total++; if (bad != 0) $display("FAIL b2b_squashed: got %0d emissions of 0x200 want 0", bad); else n_pass++;
    endtask

    task automatic test_async_reset();
        int k;
        do_reset(1'b1);
        repeat (6) tick();
        #2;
        rst_ni = 1'b0;
        #1;
        n_total++; if (instr_valid_o !== 1'b0) $display("FAIL areset_valid: got %b want 0", instr_valid_o); else n_pass++;
        n_total++; if (mem_en_o !== 1'b0) $display("FAIL areset_mem_en: got %b want 0", mem_en_o); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1; cyc = 0;
        k = 0;
        repeat (6) begin
            tick();
            if (hs && k < 2) begin
                n_total++; if (hpc !== 32'(4 * k)) $display("FAIL areset_pc%0d: got %h want %h", k, hpc, 4 * k); else n_pass++;
                n_total++; if (hcyc != LAT_RST + k) $display("FAIL areset_cycle%0d: got %0d want %0d", k, hcyc, LAT_RST + k); else n_pass++;
            end
            if (hs) k++;
        end
        n_total++; if (k < 2) $display("FAIL areset_count: got %0d want >=2", k); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, tgt;
        logic        rd;
        int          nhs;
        do_reset(1'b1);
        exp_pc = 32'h0;
        nhs = 0;
        for (int i = 0; i < 400; i++) begin
            instr_ready_i = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
            redirect_i    = rd;
            redirect_pc_i = tgt;
            tick();
            if (hs) begin
                n_total++; if (hpc !== exp_pc) $display("FAIL rand_pc: got %h want %h", hpc, exp_pc); else n_pass++;
                n_total++; if (hins !== word_at(exp_pc)) $display("FAIL rand_instr: got %h want %h", hins, word_at(exp_pc)); else n_pass++;
                exp_pc = exp_pc + 32'h4;
                nhs++;
            end
            if (rd) exp_pc = tgt & ~32'h3;
        end
        redirect_i = 1'b0;
        n_total++; if (nhs < 100) $display("FAIL rand_throughput: got %0d handshakes want >=100", nhs); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) iccm[i] = $urandom;
        iccm[0] = 32'h11; iccm[1] = 32'h22; iccm[2] = 32'h33; iccm[3] = 32'h44;
        @(negedge clk_i);
        test_reset();
        test_startup_stream();
        test_stall();
        test_redirect_flush();
        test_redirect_unaligned();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
